// File: rtl/timer_bank_pkg.sv
// Shared register map and CTRL bit positions for the timer bank.
package timer_bank_pkg;
  localparam logic [1:0] REG_RELOAD = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;
endpackage

// File: rtl/timer_channel.sv
// One down-counter channel: RELOAD/CTRL/COUNT registers plus a sticky pending flag.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_reload,
  input  logic             wr_ctrl,
  input  logic             wr_status,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] count,
  output logic [2:0]       ctrl,
  output logic             pending,
  output logic             irq_out
);
  logic [WIDTH-1:0] reload_q, reload_d, count_q, count_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             pending_q, pending_d;

  always_comb begin
    reload_d  = reload_q;
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    pending_d = pending_q;
    if (wr_reload) reload_d = wdata;
    // Clear first so an expiry on the same edge re-sets the flag.
    if (wr_status && wdata[0]) pending_d = 1'b0;
    if (wr_ctrl) begin
      // A CTRL write suppresses expiry; only a plain decrement may still happen.
      ctrl_d = wdata[2:0];
      if (wdata[CTRL_EN] && !ctrl_q[CTRL_EN])
        count_d = reload_q;
      else if (tick && wdata[CTRL_EN] && ctrl_q[CTRL_EN] && count_q != '0)
        count_d = count_q - WIDTH'(1);
    end else if (tick && ctrl_q[CTRL_EN]) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        pending_d = 1'b1;
        if (ctrl_q[CTRL_AR]) count_d = reload_q;
        else                 ctrl_d[CTRL_EN] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q  <= '0;
      ctrl_q    <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      reload_q  <= reload_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign reload  = reload_q;
  assign count   = count_q;
  assign ctrl    = ctrl_q;
  assign pending = pending_q;
  assign irq_out = pending_q & ctrl_q[CTRL_IE];
endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer: shared prescaler, register decode, registered read mux, irq OR.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int WIDTH    = 16,
  parameter  int PRESCALE = 1,
  localparam int ADDR_W   = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   ps_q, ps_d;
  logic              tick;
  logic [WIDTH-1:0]  rdata_q, rdata_d, rd_val;
  logic [ADDR_W:0]   addr_x;
  logic [ADDR_W-2:0] ch_idx;
  logic [1:0]        rsel;
  logic              ch_ok, wr_en;

  logic [NUM_CH-1:0]            wr_rl, wr_ct, wr_st, pend_v, irq_v;
  logic [NUM_CH-1:0][WIDTH-1:0] reload_v, count_v;
  logic [NUM_CH-1:0][2:0]       ctrl_v;

  assign tick = (ps_q == PS_W'(PRESCALE - 1));
  assign ps_d = tick ? '0 : ps_q + PS_W'(1);

  // Pad by one bit so the channel field exists even when NUM_CH is 1.
  assign addr_x = {1'b0, addr};
  assign ch_idx = addr_x[ADDR_W:2];
  assign rsel   = addr[1:0];
  assign ch_ok  = int'(ch_idx) < NUM_CH;
  assign wr_en  = cs & wr & ch_ok;

  always_comb begin
    wr_rl  = '0;
    wr_ct  = '0;
    wr_st  = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_ok && int'(ch_idx) == i) begin
        wr_rl[i] = wr_en && rsel == REG_RELOAD;
        wr_ct[i] = wr_en && rsel == REG_CTRL;
        wr_st[i] = wr_en && rsel == REG_STATUS;
        case (rsel)
          REG_RELOAD: rd_val = reload_v[i];
          REG_CTRL:   rd_val = WIDTH'(ctrl_v[i]);
          REG_COUNT:  rd_val = count_v[i];
          REG_STATUS: rd_val = WIDTH'(pend_v[i]);
          default:    rd_val = '0;
        endcase
      end
    end
    rdata_d = (cs && rd) ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q    <= '0;
      rdata_q <= '0;
    end else begin
      ps_q    <= ps_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .wr_reload(wr_rl[g]),
      .wr_ctrl  (wr_ct[g]),
      .wr_status(wr_st[g]),
      .wdata    (wdata),
      .reload   (reload_v[g]),
      .count    (count_v[g]),
      .ctrl     (ctrl_v[g]),
      .pending  (pend_v[g]),
      .irq_out  (irq_v[g])
    );
  end

  assign rdata   = rdata_q;
  assign irq_vec = irq_v;
  assign irq     = |irq_v;
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench: PRESCALE=1 and PRESCALE=4 banks share the bus; each test checks one of them.
module tb_timer_bank;
  logic        clk, rst, cs, wr, rd;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata1, rdata4;
  logic        irq1, irq4;
  logic [3:0]  vec1, vec4;
  int          n_cmp, n_err;

  timer_bank #(.NUM_CH(4), .WIDTH(16), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .irq(irq1), .irq_vec(vec1));

  timer_bank #(.NUM_CH(4), .WIDTH(16), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata4), .irq(irq4), .irq_vec(vec4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every bus task consumes exactly one rising edge and returns 1ns after it.
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    cyc();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a);
    cs = 1'b1; rd = 1'b1; addr = a;
    cyc();
    cs = 1'b0; rd = 1'b0;
  endtask

  // Leaves both prescalers at 0 with the next edge being the first after release.
  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    #1;
    do_reset();
    chk("rst_rdata", 32'(rdata1), 0);
    chk("rst_irq", 32'(irq1), 0);
    chk("rst_vec4", 32'(vec4), 0);

    // Reset mid-count: ch0 RELOAD=5 counting, pulse reset at COUNT=3
    wr_reg(4'd0, 16'd5);
    wr_reg(4'd1, 16'd5);
    rd_reg(4'd0);
    cyc();
    chk("pre_rst_rdata", 32'(rdata1), 5);
    rst = 1'b1;
    #2;
    chk("midrst_rdata", 32'(rdata1), 0);
    chk("midrst_irq", 32'(irq1), 0);
    do_reset();
    cyc(3);
    rd_reg(4'd2);
    chk("post_rst_count", 32'(rdata1), 0);
    rd_reg(4'd1);
    chk("post_rst_ctrl", 32'(rdata1), 0);

    // One-shot, PRESCALE=1: RELOAD=3, CTRL=101
    do_reset();
    wr_reg(4'd0, 16'd3);
    wr_reg(4'd1, 16'h5);
    cyc(3);
    chk("os_irq_early", 32'(irq1), 0);
    cyc();
    chk("os_irq_rise", 32'(irq1), 1);
    chk("os_vec", 32'(vec1), 4'b0001);
    rd_reg(4'd1);
    chk("os_ctrl", 32'(rdata1), 3'b100);
    rd_reg(4'd2);
    chk("os_count", 32'(rdata1), 0);
    wr_reg(4'd2, 16'd7);
    rd_reg(4'd2);
    chk("count_ro", 32'(rdata1), 0);
    rd_reg(4'd0);
    chk("os_reload", 32'(rdata1), 3);
    chk("os_irq_hold", 32'(irq1), 1);
    wr_reg(4'd3, 16'd1);
    chk("os_irq_clear", 32'(irq1), 0);

    // Auto-reload, PRESCALE=4: ticks land on edges 4,8,12.. after release
    do_reset();
    wr_reg(4'd4, 16'd2);
    wr_reg(4'd5, 16'h7);
    rd_reg(4'd6);
    chk("ar_count2", 32'(rdata4), 2);
    cyc(3);
    rd_reg(4'd6);
    chk("ar_count1", 32'(rdata4), 1);
    cyc(3);
    rd_reg(4'd6);
    chk("ar_count0", 32'(rdata4), 0);
    chk("ar_irq_early", 32'(irq4), 0);
    cyc();
    chk("ar_irq_rise", 32'(irq4), 1);
    chk("ar_vec", 32'(vec4), 4'b0010);
    rd_reg(4'd6);
    chk("ar_reloaded", 32'(rdata4), 2);
    wr_reg(4'd7, 16'd1);
    chk("ar_cleared", 32'(irq4), 0);
    cyc(9);
    chk("ar_irq_gap", 32'(irq4), 0);
    cyc();
    chk("ar_irq_period", 32'(irq4), 1);

    // Masking: ch2 expires with irq_en=0, then enable irq
    do_reset();
    wr_reg(4'd8, 16'd1);
    wr_reg(4'd9, 16'h3);
    cyc(2);
    rd_reg(4'd11);
    chk("mask_status", 32'(rdata1), 1);
    chk("mask_irq", 32'(irq1), 0);
    wr_reg(4'd9, 16'h7);
    chk("mask_irq_on", 32'(irq1), 1);
    chk("mask_vec", 32'(vec1), 4'b0100);

    // Collisions on ch0: RELOAD=2 auto-reload, expiries 3 and 6 edges after enable
    do_reset();
    wr_reg(4'd0, 16'd2);
    wr_reg(4'd1, 16'h7);
    cyc(2);
    wr_reg(4'd3, 16'd1);
    chk("col_clr_irq", 32'(irq1), 1);
    rd_reg(4'd3);
    chk("col_clr_status", 32'(rdata1), 1);
    wr_reg(4'd3, 16'd1);
    chk("col_plain_clr", 32'(irq1), 0);
    wr_reg(4'd1, 16'd0);
    chk("col_ctrl_irq", 32'(irq1), 0);
    rd_reg(4'd3);
    chk("col_ctrl_status", 32'(rdata1), 0);
    cyc(3);
    rd_reg(4'd2);
    chk("col_ctrl_count", 32'(rdata1), 0);

    // Multi-channel, PRESCALE=4: ch0 and ch3 loaded between ticks, expire together
    do_reset();
    wr_reg(4'd0, 16'd4);
    wr_reg(4'd12, 16'd4);
    cyc(2);
    wr_reg(4'd1, 16'h5);
    wr_reg(4'd13, 16'h5);
    cyc(17);
    chk("mc_irq_early", 32'(irq4), 0);
    cyc();
    chk("mc_vec", 32'(vec4), 4'b1001);
    wr_reg(4'd3, 16'd1);
    chk("mc_irq_ch3", 32'(irq4), 1);
    chk("mc_vec_ch3", 32'(vec4), 4'b1000);
    wr_reg(4'd15, 16'd1);
    chk("mc_irq_off", 32'(irq4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
